// File: rtl/instr_encoder.sv
// Streaming MIPS-I instruction encoder: packs native fields into 32-bit words and
// expands the LI / LA / MOVE pseudo-ops, with a one-word holding register plus one pending word.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_pseudo,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [31:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      ir,
  output logic             err_valid,
  output logic [7:0]       exception,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [7:0] TRAP_BAD_INSTRUCTION = 8'h0A;

  localparam logic [1:0] PS_NATIVE = 2'b00;
  localparam logic [1:0] PS_LI     = 2'b01;
  localparam logic [1:0] PS_MOVE   = 2'b10;
  localparam logic [1:0] PS_LA     = 2'b11;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_ADDU    = 6'b100001;

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    FULL      = 2'b01,
    FULL_PEND = 2'b10
  } state_t;

  state_t           state_q;
  logic [31:0]      ir_q;
  logic [31:0]      pend_q;
  logic             err_q;
  logic [7:0]       exc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [31:0] enc_w0;
  logic [31:0] enc_w1;
  logic        enc_two;
  logic        enc_bad;
  logic        accept;
  logic        consume;
  logic        push;

  function automatic logic native_ok(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] rt);
    logic ok;
    ok = 1'b0;
    if (op == OP_SPECIAL) begin
      ok = (fn inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                       6'b000111, 6'b001000, 6'b001001, 6'b001100,
                       [6'b100000:6'b100111], 6'b101010, 6'b101011});
    end else if (op == OP_REGIMM) begin
      ok = (rt inside {5'b00000, 5'b00001, 5'b10001});
    end else begin
      ok = (op inside {[6'b000010:6'b001111], 6'b100000, 6'b100011, 6'b100100,
                       6'b101000, 6'b101011});
    end
    return ok;
  endfunction

  always_comb begin
    enc_w0  = 32'd0;
    enc_w1  = 32'd0;
    enc_two = 1'b0;
    enc_bad = 1'b0;
    case (in_pseudo)
      PS_NATIVE: begin
        enc_bad = !native_ok(in_opcode, in_funct, in_rt);
        if (in_opcode == OP_SPECIAL)
          enc_w0 = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
        else if (in_opcode == OP_J || in_opcode == OP_JAL)
          enc_w0 = {in_opcode, in_target};
        else
          enc_w0 = {in_opcode, in_rs, in_rt, in_imm[15:0]};
      end
      PS_LI: begin
        // Pick the shortest form that reproduces the full 32-bit constant.
        if ((&in_imm[31:15]) || !(|in_imm[31:15])) begin
          enc_w0 = {OP_ADDIU, 5'd0, in_rt, in_imm[15:0]};
        end else if (in_imm[31:16] == 16'd0) begin
          enc_w0 = {OP_ORI, 5'd0, in_rt, in_imm[15:0]};
        end else if (in_imm[15:0] == 16'd0) begin
          enc_w0 = {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
        end else begin
          enc_w0  = {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
          enc_w1  = {OP_ORI, in_rt, in_rt, in_imm[15:0]};
          enc_two = 1'b1;
        end
      end
      PS_MOVE: begin
        enc_w0 = {OP_SPECIAL, in_rs, 5'd0, in_rd, 5'd0, FN_ADDU};
      end
      PS_LA: begin
        enc_w0  = {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
        enc_w1  = {OP_ORI, in_rt, in_rt, in_imm[15:0]};
        enc_two = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready   = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
  assign out_valid  = (state_q != EMPTY);
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid && out_ready;
  assign push       = accept && !enc_bad;
  assign cnt_d      = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ir_q    <= 32'd0;
      pend_q  <= 32'd0;
      err_q   <= 1'b0;
      exc_q   <= 8'd0;
      cnt_q   <= '0;
    end else begin
      err_q <= accept && enc_bad;
      exc_q <= (accept && enc_bad) ? TRAP_BAD_INSTRUCTION : 8'd0;
      if (consume)
        cnt_q <= cnt_d;
      case (state_q)
        EMPTY, FULL: begin
          // In FULL a push is only possible when the held word leaves this same cycle.
          if (push) begin
            ir_q    <= enc_w0;
            pend_q  <= enc_w1;
            state_q <= enc_two ? FULL_PEND : FULL;
          end else if (consume) begin
            state_q <= EMPTY;
          end
        end
        FULL_PEND: begin
          if (consume) begin
            ir_q    <= pend_q;
            pend_q  <= 32'd0;
            state_q <= FULL;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign ir         = ir_q;
  assign err_valid  = err_q;
  assign exception  = exc_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based reference model checked every cycle,
// directed sequences with literal expectations, then randomized traffic.
module tb_instr_encoder;

  localparam int CNT_W = 16;
  localparam logic [7:0] TRAP = 8'h0A;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_pseudo = 2'b00;
  logic [5:0]       in_opcode = 6'd0;
  logic [5:0]       in_funct = 6'd0;
  logic [4:0]       in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
  logic [31:0]      in_imm = 32'd0;
  logic [25:0]      in_target = 26'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      ir;
  logic             err_valid;
  logic [7:0]       exception;
  logic [CNT_W-1:0] word_count;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pseudo(in_pseudo), .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
    .out_ready(out_ready), .ir(ir), .err_valid(err_valid),
    .exception(exception), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0]      mq[$];
  logic             exp_err = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit supported(input int op, input int fn, input int rt);
    int ops[20] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,32,35,36,40,43};
    int fns[19] = '{0,2,3,4,6,7,8,9,12,32,33,34,35,36,37,38,39,42,43};
    if (op == 0) begin
      foreach (fns[i]) if (fns[i] == fn) return 1'b1;
      return 1'b0;
    end
    if (op == 1) return (rt == 0 || rt == 1 || rt == 17);
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Words a request must produce, from the instruction-set rules.
  function automatic void model_words(output int n, output logic [31:0] a, output logic [31:0] b);
    int op, rs, rt, rd;
    longint sv;
    op = int'(in_opcode); rs = int'(in_rs); rt = int'(in_rt); rd = int'(in_rd);
    n = 1; a = 32'd0; b = 32'd0;
    sv = longint'($signed(in_imm));
    case (in_pseudo)
      2'b00: begin
        if (!supported(op, int'(in_funct), rt)) n = 0;
        else if (op == 0)
          a = (rs << 21) + (rt << 16) + (rd << 11) + (int'(in_shamt) << 6) + int'(in_funct);
        else if (op == 2 || op == 3)
          a = (op << 26) + int'(in_target);
        else
          a = (op << 26) + (rs << 21) + (rt << 16) + (in_imm % 65536);
      end
      2'b01: begin
        if (sv >= -32768 && sv <= 32767) a = (9 << 26) + (rt << 16) + (in_imm % 65536);
        else if (in_imm < 65536)          a = (13 << 26) + (rt << 16) + in_imm;
        else if (in_imm % 65536 == 0)     a = (15 << 26) + (rt << 16) + (in_imm / 65536);
        else begin
          n = 2;
          a = (15 << 26) + (rt << 16) + (in_imm / 65536);
          b = (13 << 26) + (rt << 21) + (rt << 16) + (in_imm % 65536);
        end
      end
      2'b10: a = (rs << 21) + (rd << 11) + 33;
      default: begin
        n = 2;
        a = (15 << 26) + (rt << 16) + (in_imm / 65536);
        b = (13 << 26) + (rt << 21) + (rt << 16) + (in_imm % 65536);
      end
    endcase
  endfunction

  // Per-cycle compare, sampled on the falling edge; then advance the model across the next rising edge.
  always @(negedge clk) begin
    int n;
    logic [31:0] a, b;
    bit exp_rdy, cons, acc;
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ir", ir, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      mq.delete();
      exp_err = 1'b0;
      exp_cnt = '0;
    end else begin
      exp_rdy = (mq.size() == 0) || (mq.size() == 1 && out_ready);
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("ir", ir, mq[0]);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("err_valid", 32'(err_valid), 32'(exp_err));
      chk("exception", 32'(exception), exp_err ? 32'(TRAP) : 32'd0);
      chk("word_count", 32'(word_count), 32'(exp_cnt));
      cons = (mq.size() != 0) && out_ready;
      acc  = in_valid && exp_rdy;
      if (cons) begin
        void'(mq.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      exp_err = 1'b0;
      if (acc) begin
        model_words(n, a, b);
        if (n == 0) exp_err = 1'b1;
        if (n >= 1) mq.push_back(a);
        if (n == 2) mq.push_back(b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] ps, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [31:0] imm);
    in_valid = 1'b1; in_pseudo = ps; in_opcode = op; in_funct = fn;
    in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = 5'd0; in_imm = imm; in_target = 26'd0;
  endtask

  logic [31:0] li_imm[3] = '{32'hFFFFFFFF, 32'h0000ABCD, 32'h00120000};
  logic [31:0] li_exp[3] = '{32'h2408FFFF, 32'h3408ABCD, 32'h3C080012};
  logic [5:0]  bad_op[3] = '{6'b010000, 6'b000001, 6'b000000};
  logic [4:0]  bad_rt[3] = '{5'd0, 5'b00010, 5'd0};
  logic [5:0]  bad_fn[3] = '{6'd0, 6'd0, 6'b001101};
  logic [5:0]  good_ops[20] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,32,35,36,40,43};

  initial begin
    #2;
    chk("reset_in_ready_async", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Native addu
    out_ready = 1'b1;
    req(2'b00, 6'd0, 6'b100001, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("addu_ir", ir, 32'h00221821);
    chk("addu_valid", 32'(out_valid), 32'd1);
    tick();
    chk("addu_count", 32'(word_count), 32'd1);

    // LI two-word expansion
    req(2'b01, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 32'h12345678);
    tick();
    in_valid = 1'b0;
    chk("li2_w0", ir, 32'h3C081234);
    chk("li2_ready_pend", 32'(in_ready), 32'd0);
    tick();
    chk("li2_w1", ir, 32'h35085678);
    chk("li2_ready_after", 32'(in_ready), 32'd1);
    tick();

    // LI single-word forms
    for (int i = 0; i < 3; i++) begin
      req(2'b01, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, li_imm[i]);
      tick();
      in_valid = 1'b0;
      chk("li1_word", ir, li_exp[i]);
      tick();
    end
    chk("li_count", 32'(word_count), 32'd6);

    // LA with downstream stall
    out_ready = 1'b0;
    req(2'b11, 6'd0, 6'd0, 5'd0, 5'd8, 5'd0, 32'h12345678);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("la_hold_ir", ir, 32'h3C081234);
      chk("la_hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("la_w1", ir, 32'h35085678);
    chk("la_ready_after", 32'(in_ready), 32'd1);
    tick();

    // Rejected requests
    for (int i = 0; i < 3; i++) begin
      req(2'b00, bad_op[i], bad_fn[i], 5'd1, bad_rt[i], 5'd1, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("bad_no_word", 32'(out_valid), 32'd0);
      chk("bad_err", 32'(err_valid), 32'd1);
      chk("bad_exc", 32'(exception), 32'(TRAP));
      tick();
      chk("bad_err_pulse", 32'(err_valid), 32'd0);
      chk("bad_count", 32'(word_count), 32'd8);
    end

    // Asynchronous reset in FULL_PEND
    out_ready = 1'b0;
    req(2'b11, 6'd0, 6'd0, 5'd0, 5'd9, 5'd0, 32'hCAFEBABE);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ir", ir, 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    req(2'b10, 6'd0, 6'd0, 5'd4, 5'd0, 5'd5, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("post_rst_move", ir, 32'h00802821);
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_pseudo = 2'($urandom_range(0, 3));
      in_opcode = ($urandom_range(0, 1) != 0) ? good_ops[$urandom_range(0, 19)]
                : (($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom));
      in_funct  = ($urandom_range(0, 2) == 0) ? 6'b100001 : 6'($urandom);
      in_rs = 5'($urandom); in_rd = 5'($urandom); in_shamt = 5'($urandom);
      in_rt = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
      in_target = 26'($urandom);
      case ($urandom_range(0, 3))
        0: in_imm = $urandom;
        1: in_imm = {{16{1'b1}}, 16'($urandom)};
        2: in_imm = {16'd0, 16'($urandom)};
        default: in_imm = {16'($urandom), 16'd0};
      endcase
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
